// File: rtl/meep_axil_periph_xbar.sv
// rtl/meep_axil_periph_xbar.sv - AXI4-Lite 1-to-N address-decoded peripheral bridge
// Optional response timeout with late-response drain: define MEEP_AXIL_TIMEOUT_EN.
module meep_axil_periph_xbar #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter logic [N_PORTS*ADDR_W-1:0] BASE_ADDRS = {13'h1000, 13'h0000},
  parameter logic [N_PORTS*ADDR_W-1:0] ADDR_MASKS = {13'h1000, 13'h1000},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         chipset_clk,
  input  logic                         chipset_rst_n,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [N_PORTS*ADDR_W-1:0]    m_axi_awaddr,
  output logic [N_PORTS-1:0]           m_axi_awvalid,
  input  logic [N_PORTS-1:0]           m_axi_awready,
  output logic [N_PORTS*DATA_W-1:0]    m_axi_wdata,
  output logic [N_PORTS*DATA_W/8-1:0]  m_axi_wstrb,
  output logic [N_PORTS-1:0]           m_axi_wvalid,
  input  logic [N_PORTS-1:0]           m_axi_wready,
  input  logic [N_PORTS*2-1:0]         m_axi_bresp,
  input  logic [N_PORTS-1:0]           m_axi_bvalid,
  output logic [N_PORTS-1:0]           m_axi_bready,
  output logic [N_PORTS*ADDR_W-1:0]    m_axi_araddr,
  output logic [N_PORTS-1:0]           m_axi_arvalid,
  input  logic [N_PORTS-1:0]           m_axi_arready,
  input  logic [N_PORTS*DATA_W-1:0]    m_axi_rdata,
  input  logic [N_PORTS*2-1:0]         m_axi_rresp,
  input  logic [N_PORTS-1:0]           m_axi_rvalid,
  output logic [N_PORTS-1:0]           m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_WAIT  = 2'd2;
  localparam logic [1:0] W_RESP  = 2'd3;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

  // Returns {hit, index}; scanning downward lets the lowest matching port win.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if ((addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) ==
          (BASE_ADDRS[i*ADDR_W +: ADDR_W] & ADDR_MASKS[i*ADDR_W +: ADDR_W]))
        res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  function automatic logic [N_PORTS-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [N_PORTS-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  logic [1:0]          w_state;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [SEL_W-1:0]    w_sel;
  logic                aw_pend, w_pend;
  logic [N_PORTS-1:0]  m_awvalid_q, m_wvalid_q;
  logic                s_bvalid_q;
  logic [1:0]          s_bresp_q;

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [SEL_W-1:0]    r_sel;
  logic                ar_pend;
  logic [N_PORTS-1:0]  m_arvalid_q;
  logic                s_rvalid_q;
  logic [1:0]          s_rresp_q;
  logic [DATA_W-1:0]   s_rdata_q;

  logic                aw_hs, w_hs, w_both, ar_hs;
  logic [ADDR_W-1:0]   aw_addr_nx;
  logic [SEL_W:0]      aw_dec, ar_dec;
  logic                aw_pend_nx, w_pend_nx, ar_pend_nx;
  logic                w_progress, r_progress;
  logic                w_fire, r_fire, w_blocked, r_blocked;
  logic [N_PORTS-1:0]  w_drain, r_drain;

  assign s_axi_awready = (w_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = (w_state == W_IDLE) && !w_held;
  assign s_axi_arready = (r_state == R_IDLE);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  // Decode on the edge that completes the AW/W pair so the issue is one cycle later.
  assign w_both     = (aw_held || aw_hs) && (w_held || w_hs);
  assign aw_addr_nx = aw_held ? aw_addr_q : s_axi_awaddr;
  assign aw_dec     = decode(aw_addr_nx);
  assign ar_dec     = decode(s_axi_araddr);

  assign aw_pend_nx = aw_pend && !(m_awvalid_q[w_sel] && m_axi_awready[w_sel]);
  assign w_pend_nx  = w_pend && !(m_wvalid_q[w_sel] && m_axi_wready[w_sel]);
  assign ar_pend_nx = ar_pend && !(m_arvalid_q[r_sel] && m_axi_arready[r_sel]);
  assign w_progress = ((w_state == W_ISSUE) && !aw_pend_nx && !w_pend_nx) ||
                      ((w_state == W_WAIT) && m_axi_bvalid[w_sel]);
  assign r_progress = ((r_state == R_ISSUE) && !ar_pend_nx) ||
                      ((r_state == R_WAIT) && m_axi_rvalid[r_sel]);

  assign s_axi_bvalid  = s_bvalid_q;
  assign s_axi_bresp   = s_bresp_q;
  assign s_axi_rvalid  = s_rvalid_q;
  assign s_axi_rresp   = s_rresp_q;
  assign s_axi_rdata   = s_rdata_q;
  assign m_axi_awaddr  = {N_PORTS{aw_addr_q}};
  assign m_axi_wdata   = {N_PORTS{w_data_q}};
  assign m_axi_wstrb   = {N_PORTS{w_strb_q}};
  assign m_axi_araddr  = {N_PORTS{ar_addr_q}};
  assign m_axi_awvalid = m_awvalid_q;
  assign m_axi_wvalid  = m_wvalid_q;
  assign m_axi_arvalid = m_arvalid_q;
  assign m_axi_bready  = ((w_state == W_WAIT) ? onehot(w_sel) : '0) | w_drain;
  assign m_axi_rready  = ((r_state == R_WAIT) ? onehot(r_sel) : '0) | r_drain;

`ifdef MEEP_AXIL_TIMEOUT_EN
  logic [15:0]        w_cnt, r_cnt;
  logic [N_PORTS-1:0] w_drain_q, r_drain_q;

  assign w_drain   = w_drain_q;
  assign r_drain   = r_drain_q;
  assign w_blocked = (w_state == W_ISSUE) && w_drain_q[w_sel];
  assign r_blocked = (r_state == R_ISSUE) && r_drain_q[r_sel];
  assign w_fire = ((w_state == W_ISSUE) || (w_state == W_WAIT)) && !w_blocked &&
                  !w_progress && (w_cnt >= 16'(TIMEOUT_CYCLES - 1));
  assign r_fire = ((r_state == R_ISSUE) || (r_state == R_WAIT)) && !r_blocked &&
                  !r_progress && (r_cnt >= 16'(TIMEOUT_CYCLES - 1));

  // A timed-out port keeps its ready up until one late response has been swallowed.
  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      w_cnt     <= '0;
      r_cnt     <= '0;
      w_drain_q <= '0;
      r_drain_q <= '0;
    end else begin
      if ((w_state == W_IDLE) || (w_state == W_RESP) || w_progress) w_cnt <= '0;
      else if (!w_blocked) w_cnt <= w_cnt + 16'd1;
      if ((r_state == R_IDLE) || (r_state == R_RESP) || r_progress) r_cnt <= '0;
      else if (!r_blocked) r_cnt <= r_cnt + 16'd1;
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_drain_q[i] && m_axi_bvalid[i]) w_drain_q[i] <= 1'b0;
        if (r_drain_q[i] && m_axi_rvalid[i]) r_drain_q[i] <= 1'b0;
      end
      if (w_fire) w_drain_q[w_sel] <= 1'b1;
      if (r_fire) r_drain_q[r_sel] <= 1'b1;
    end
  end
`else
  assign w_drain   = '0;
  assign r_drain   = '0;
  assign w_blocked = 1'b0;
  assign r_blocked = 1'b0;
  assign w_fire    = 1'b0;
  assign r_fire    = 1'b0;
`endif

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      w_sel       <= '0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
          end
          if (w_both) begin
            if (aw_dec[SEL_W]) begin
              w_sel       <= aw_dec[SEL_W-1:0];
              aw_pend     <= 1'b1;
              w_pend      <= 1'b1;
              m_awvalid_q <= w_drain[aw_dec[SEL_W-1:0]] ? '0 : onehot(aw_dec[SEL_W-1:0]);
              m_wvalid_q  <= w_drain[aw_dec[SEL_W-1:0]] ? '0 : onehot(aw_dec[SEL_W-1:0]);
              w_state     <= W_ISSUE;
            end else begin
              s_bvalid_q <= 1'b1;
              s_bresp_q  <= 2'b11;
              w_state    <= W_RESP;
            end
          end
        end
        W_ISSUE: begin
          if (w_fire) begin
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            s_bvalid_q  <= 1'b1;
            s_bresp_q   <= 2'b10;
            w_state     <= W_RESP;
          end else if (!w_blocked) begin
            aw_pend     <= aw_pend_nx;
            w_pend      <= w_pend_nx;
            m_awvalid_q <= aw_pend_nx ? onehot(w_sel) : '0;
            m_wvalid_q  <= w_pend_nx ? onehot(w_sel) : '0;
            if (!aw_pend_nx && !w_pend_nx) w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (m_axi_bvalid[w_sel]) begin
            s_bresp_q  <= m_axi_bresp[w_sel*2 +: 2];
            s_bvalid_q <= 1'b1;
            w_state    <= W_RESP;
          end else if (w_fire) begin
            s_bresp_q  <= 2'b10;
            s_bvalid_q <= 1'b1;
            w_state    <= W_RESP;
          end
        end
        default: begin
          if (s_axi_bready) begin
            s_bvalid_q <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            w_state    <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      r_state     <= R_IDLE;
      ar_addr_q   <= '0;
      r_sel       <= '0;
      ar_pend     <= 1'b0;
      m_arvalid_q <= '0;
      s_rvalid_q  <= 1'b0;
      s_rresp_q   <= 2'b00;
      s_rdata_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr_q <= s_axi_araddr;
            if (ar_dec[SEL_W]) begin
              r_sel       <= ar_dec[SEL_W-1:0];
              ar_pend     <= 1'b1;
              m_arvalid_q <= r_drain[ar_dec[SEL_W-1:0]] ? '0 : onehot(ar_dec[SEL_W-1:0]);
              r_state     <= R_ISSUE;
            end else begin
              s_rvalid_q <= 1'b1;
              s_rresp_q  <= 2'b11;
              s_rdata_q  <= '0;
              r_state    <= R_RESP;
            end
          end
        end
        R_ISSUE: begin
          if (r_fire) begin
            m_arvalid_q <= '0;
            ar_pend     <= 1'b0;
            s_rvalid_q  <= 1'b1;
            s_rresp_q   <= 2'b10;
            s_rdata_q   <= '0;
            r_state     <= R_RESP;
          end else if (!r_blocked) begin
            ar_pend     <= ar_pend_nx;
            m_arvalid_q <= ar_pend_nx ? onehot(r_sel) : '0;
            if (!ar_pend_nx) r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (m_axi_rvalid[r_sel]) begin
            s_rdata_q  <= m_axi_rdata[r_sel*DATA_W +: DATA_W];
            s_rresp_q  <= m_axi_rresp[r_sel*2 +: 2];
            s_rvalid_q <= 1'b1;
            r_state    <= R_RESP;
          end else if (r_fire) begin
            s_rdata_q  <= '0;
            s_rresp_q  <= 2'b10;
            s_rvalid_q <= 1'b1;
            r_state    <= R_RESP;
          end
        end
        default: begin
          if (s_axi_rready) begin
            s_rvalid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_state    <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule
